flag_branch_unit: RTL
=====================

// Module: flag_branch_unit
// PURPOSE
//  Consumer end of the ALU flagZVN interface: holds architectural Z/V/N flags, applies per-opcode
//  update masks, resolves 3-bit branch conditions for the instruction in ID. Sits between EX (ALU)
//  and ID (branch/PC logic). Handles the EX->ID flag hazard and keeps saturating branch statistics.
// PARAMETERS
//  CNT_W        16      width of branch statistic counters
//  RESET_FLAGS  3'b000  {Z,V,N} value loaded on reset
// PORTS
//  clk          in   1      clock, all state updates on posedge
//  rst          in   1      synchronous reset, active-high
//  ex_valid     in   1      EX holds a real (non-bubble) instruction
//  ex_opcode    in   4      EX instruction opcode, inst[15:12]
//  ex_flagZVN   in   3      ALU flag output {Z,V,N} for the EX instruction
//  id_valid     in   1      ID holds a real instruction
//  id_is_branch in   1      ID instruction is B/BR
//  id_cond      in   3      ID branch condition ccc
//  id_flush     in   1      ID instruction being squashed this cycle
//  cnt_clr      in   1      clear both statistic counters
//  flags_q      out  3      architectural flag register {Z,V,N}
//  br_taken     out  1      ID branch resolves taken (combinational)
//  br_stall     out  1      hold ID/IF one cycle for flag hazard (combinational)
//  br_count     out  CNT_W  resolved branches
//  br_tkn_count out  CNT_W  resolved taken branches
// BEHAVIOUR
//  - Reset: flags_q=RESET_FLAGS, br_count=0, br_tkn_count=0; rst overrides every other input,
//    including mid-hazard (no pending state survives reset).
//  - Flag write mask (applied only when ex_valid=1, committed at next posedge):
//    opcode 0,1 (ADD,SUB): write Z,V,N; opcode 2,4,5,6 (XOR,SLL,SRA,ROR): write Z only;
//    opcode 3,7 and 8-15: no write. Unwritten bits hold their value.
//  - nextZVN = flags_q with masked bits replaced by ex_flagZVN.
//  - Condition on flag vector F={Z,V,N}:
//    000 NE: !Z | 001 EQ: Z | 010 GT: !Z&!N | 011 LT: N | 100 GE: Z|(!Z&!N)
//    101 LE: N|Z | 110 OV: V | 111 always
//  - hazard = id_valid & id_is_branch & id_cond!=3'b111 & ex_valid & (ex mask != 0).
//  - br_taken = id_valid & id_is_branch & !id_flush & !br_stall & cond(F_eff).
//  - id_flush=1 forces br_taken=0 and br_stall=0; no counter update.
//  - Resolved branch: id_valid & id_is_branch & !id_flush & !br_stall. On posedge, br_count+=1
//    and, if br_taken, br_tkn_count+=1. Counters saturate at all-ones (no wrap).
//  - cnt_clr: both counters -> 0 at posedge; clear wins over a same-cycle increment.
//  - Simultaneous flag write and branch resolve: the branch uses F_eff (below); flags_q updates
//    regardless.
// CONFIGURATION
//  FLAG_FWD_EN defined: F_eff = nextZVN (bypass of EX flags); br_stall held 0; a dependent
//    branch resolves in the same cycle as the flag-setting instruction.
//  FLAG_FWD_EN undefined: F_eff = flags_q; br_stall = hazard & !id_flush. Pipeline holds ID, EX
//    receives a bubble; the branch resolves the following cycle on the updated flags_q.
// TESTING
//  1 rst=1 for one cycle -> flags_q=000, br_count=0, br_tkn_count=0, br_taken=0.
//  2 ex_valid, op=0, ex_flagZVN=011 -> flags_q=011; then op=2, ex_flagZVN=100 -> flags_q=111.
//  3 flags_q=111, ex_valid, op=3 or 9, ex_flagZVN=000 -> flags_q stays 111.
//  4 flags_q=010, no EX write, branch cond=110 -> br_taken=1, br_stall=0, br_tkn_count+1.
//  5 flags_q=000, EX op=1 ex_flagZVN=100, ID branch cond=001: FWD on -> br_taken=1 same cycle;
//    FWD off -> br_stall=1, br_taken=0, then next cycle br_taken=1, br_count+1 only once.
//  6 CNT_W=4: 20 taken cond=111 branches -> both counters =15; cnt_clr with branch -> both 0.

Source files
------------

// File: rtl/flag_branch_unit_if.sv
// rtl/flag_branch_unit_if.sv - EX/ID flag and branch signal bundle for flag_branch_unit
//
// Purpose: groups the EX-stage flag inputs, ID-stage branch inputs, statistics
//          clear and the unit's flag/branch/statistic outputs.
// Parameters:
//   CNT_W         width of the branch statistic counters
// Signals (direction seen from the slave = flag_branch_unit):
//   ex_valid      in   1      EX holds a real instruction
//   ex_opcode     in   4      EX opcode, inst[15:12]
//   ex_flagZVN    in   3      ALU flags {Z,V,N} of the EX instruction
//   id_valid      in   1      ID holds a real instruction
//   id_is_branch  in   1      ID instruction is B/BR
//   id_cond       in   3      ID branch condition ccc
//   id_flush      in   1      ID instruction squashed this cycle
//   cnt_clr       in   1      clear both statistic counters
//   flags_q       out  3      architectural flags {Z,V,N}
//   br_taken      out  1      ID branch resolves taken
//   br_stall      out  1      hold ID/IF one cycle for the flag hazard
//   br_count      out  CNT_W  resolved branches
//   br_tkn_count  out  CNT_W  resolved taken branches
interface flag_branch_unit_if #(
    parameter int CNT_W = 16
);
    logic             ex_valid;
    logic [3:0]       ex_opcode;
    logic [2:0]       ex_flagZVN;
    logic             id_valid;
    logic             id_is_branch;
    logic [2:0]       id_cond;
    logic             id_flush;
    logic             cnt_clr;
    logic [2:0]       flags_q;
    logic             br_taken;
    logic             br_stall;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] br_tkn_count;

    modport master (
        output ex_valid, ex_opcode, ex_flagZVN,
        output id_valid, id_is_branch, id_cond, id_flush,
        output cnt_clr,
        input  flags_q, br_taken, br_stall, br_count, br_tkn_count
    );

    modport slave (
        input  ex_valid, ex_opcode, ex_flagZVN,
        input  id_valid, id_is_branch, id_cond, id_flush,
        input  cnt_clr,
        output flags_q, br_taken, br_stall, br_count, br_tkn_count
    );
endinterface

// File: rtl/flag_branch_unit.sv
// rtl/flag_branch_unit.sv - architectural Z/V/N flags, branch resolution and branch statistics
//
// Purpose: consumer of the ALU flag output. Commits per-opcode masked flag
//          updates from EX, resolves the ID branch condition, handles the
//          EX->ID flag hazard and keeps saturating branch counters.
// Parameters:
//   CNT_W         width of br_count / br_tkn_count
//   RESET_FLAGS   {Z,V,N} loaded on reset
// Build option:
//   FLAG_FWD_EN   defined: branch sees the EX flags through a bypass, never stalls.
//                 undefined: branch sees flags_q and stalls one cycle on a hazard.
// Ports:
//   clk           clock, all state on posedge
//   rst           synchronous reset, active-high
//   bus           flag_branch_unit_if.slave (EX flags in, ID branch in, results out)
module flag_branch_unit #(
    parameter int         CNT_W       = 16,
    parameter logic [2:0] RESET_FLAGS = 3'b000
) (
    input  logic                clk,
    input  logic                rst,
    flag_branch_unit_if.slave   bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [2:0]       r_flags;
    logic [CNT_W-1:0] r_br_count;
    logic [CNT_W-1:0] r_br_tkn_count;

    logic [2:0]       w_mask;
    logic [2:0]       w_next_flags;
    logic [2:0]       w_f_eff;
    logic             w_stall;
    logic             w_resolve;
    logic             w_taken;

    // Which of {Z,V,N} an opcode writes: arithmetic writes all three,
    // logic/shift ops write Z only, everything else leaves the flags alone.
    function automatic logic [2:0] flag_mask(input logic [3:0] op);
        logic [2:0] m;
        case (op)
            4'd0, 4'd1:             m = 3'b111;
            4'd2, 4'd4, 4'd5, 4'd6: m = 3'b100;
            default:                m = 3'b000;
        endcase
        return m;
    endfunction

    // Branch condition on f = {Z,V,N}.
    function automatic logic cond_eval(input logic [2:0] cc, input logic [2:0] f);
        logic z;
        logic v;
        logic n;
        logic t;
        z = f[2];
        v = f[1];
        n = f[0];
        case (cc)
            3'b000:  t = !z;
            3'b001:  t = z;
            3'b010:  t = !z && !n;
            3'b011:  t = n;
            3'b100:  t = z || (!z && !n);
            3'b101:  t = n || z;
            3'b110:  t = v;
            default: t = 1'b1;
        endcase
        return t;
    endfunction

    // A bubble in EX writes nothing.
    assign w_mask       = bus.ex_valid ? flag_mask(bus.ex_opcode) : 3'b000;
    assign w_next_flags = (r_flags & ~w_mask) | (bus.ex_flagZVN & w_mask);

`ifdef FLAG_FWD_EN
    // Bypass: the branch evaluates on the flags EX is about to commit,
    // so there is never a reason to hold ID.
    assign w_f_eff = w_next_flags;
    assign w_stall = 1'b0;
`else
    logic w_hazard;

    // An unconditional branch does not depend on flags, so it never waits.
    assign w_hazard = bus.id_valid && bus.id_is_branch && (bus.id_cond != 3'b111)
                      && (w_mask != 3'b000);
    assign w_f_eff  = r_flags;
    assign w_stall  = w_hazard && !bus.id_flush;
`endif

    assign w_resolve = bus.id_valid && bus.id_is_branch && !bus.id_flush && !w_stall;
    assign w_taken   = w_resolve && cond_eval(bus.id_cond, w_f_eff);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flags        <= RESET_FLAGS;
            r_br_count     <= '0;
            r_br_tkn_count <= '0;
        end else begin
            r_flags <= w_next_flags;
            // Clear takes priority over an increment in the same cycle.
            if (bus.cnt_clr) begin
                r_br_count     <= '0;
                r_br_tkn_count <= '0;
            end else if (w_resolve) begin
                if (r_br_count != CNT_MAX) begin
                    r_br_count <= r_br_count + CNT_ONE;
                end
                if (w_taken && (r_br_tkn_count != CNT_MAX)) begin
                    r_br_tkn_count <= r_br_tkn_count + CNT_ONE;
                end
            end
        end
    end

    assign bus.flags_q      = r_flags;
    assign bus.br_taken     = w_taken;
    assign bus.br_stall     = w_stall;
    assign bus.br_count     = r_br_count;
    assign bus.br_tkn_count = r_br_tkn_count;
endmodule
